cdb_writeback: RTL and testbench
================================

CDB_WRITEBACK -- requirements
Module: cdb_writeback

Interface
REQ-001 Parameter: DATA_W, 16, width of result value.
REQ-002 Parameter: TAG_W, 3, reservation-station tag width (0-3 add/sub entries, 4-7 mul/div entries).
REQ-003 Parameter: NUM_FU, 3, result sources (0 = F0 add/sub, 1 = F1 add/sub, 2 = F3 mul/div).
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: flush  input  1  synchronous clear of all buffered results.
REQ-007 Port: fu_valid  input  NUM_FU  per-FU result-present strobe.
REQ-008 Port: fu_tag  input  NUM_FU*TAG_W  per-FU producing-entry tag.
REQ-009 Port: fu_value  input  NUM_FU*DATA_W  per-FU result value.
REQ-010 Port: fu_ready  output  NUM_FU  per-FU accept; the transfer occurs when fu_valid & fu_ready.
REQ-011 Port: cdb_valid  output  1  broadcast strobe, one result per cycle.
REQ-012 Port: cdb_tag  output  TAG_W  tag of the broadcast result.
REQ-013 Port: cdb_value  output  DATA_W  broadcast value.
REQ-014 Port: cdb_src  output  2  FU index of the broadcast result.
REQ-015 Port: fu_release  output  NUM_FU  one-cycle pulse freeing the FU execution unit, coincident with cdb_valid for that FU.

Function
REQ-016 The block SHALL hold one result register (valid, tag, value) per FU.
REQ-017 fu_ready[i] SHALL equal !hold_valid[i] OR (hold i granted this cycle), giving same-cycle drain and refill.
REQ-018 An accepted result SHALL be captured on the accept edge and SHALL be eligible for broadcast the following cycle; minimum latency accept-to-cdb_valid is 1 cycle.
REQ-019 Each cycle, the block SHALL grant at most one valid hold, round-robin: search from rr_ptr upward modulo NUM_FU; first valid hold wins.
REQ-020 On a grant to index g, rr_ptr SHALL become (g+1) mod NUM_FU; with no grant, rr_ptr SHALL be unchanged.
REQ-021 cdb_valid, cdb_tag, cdb_value, cdb_src and fu_release SHALL be registered; the granted hold SHALL clear on the same edge at which these outputs load.
REQ-022 With no valid hold, cdb_valid SHALL be 0, fu_release SHALL be 0, and cdb_tag, cdb_value and cdb_src SHALL retain their previous values.
REQ-023 When hold i is full and not granted, fu_ready[i] SHALL be 0; the FU SHALL keep fu_valid, fu_tag and fu_value stable, and no result SHALL be lost or duplicated.
REQ-024 Simultaneous fu_valid on all three FUs with empty holds SHALL be accepted in one cycle and broadcast on three consecutive cycles in rr order.
REQ-025 Value width SHALL pass unmodified: no truncation or sign handling.
REQ-026 flush SHALL clear all hold_valid bits and cdb_valid and fu_release on the next edge, and SHALL force fu_ready low during the flush cycle.
REQ-027 flush SHALL leave rr_ptr unchanged.

Reset
REQ-028 On rst_n low, the block SHALL immediately clear hold_valid, cdb_valid and fu_release, zero cdb_tag, cdb_value and cdb_src, and set rr_ptr to 0.
REQ-029 fu_ready SHALL read all-ones after reset deassertion.
REQ-030 Reset asserted mid-broadcast SHALL discard all buffered results without emitting a partial broadcast.

Structure
REQ-031 DATA_W, TAG_W, NUM_FU and the FU index constants FU_ADD0=0, FU_ADD1=1, FU_MULDIV=2 SHALL live in the shared package tomasulo_pkg.
REQ-032 Arbitration SHALL be a sub-module rr_arbiter3: request[2:0] and ptr in; one-hot grant and any_grant out; purely combinational.
REQ-033 The hold registers, rr_ptr and output registers SHALL reside in cdb_writeback.

Verification
REQ-034 Single result: F0 presents tag 2, value 0x0007 at cycle 0 -> cycle 1 cdb_valid=1, cdb_tag=2, cdb_value=0x0007, cdb_src=0, fu_release=001.
REQ-035 Three-way collision: F0 (tag 0, 0x0001), F1 (tag 1, 0x0002) and F3 (tag 4, 0x0030) all at cycle 0 with rr_ptr=0 -> broadcasts tags 0, 1, 4 on cycles 1, 2, 3; rr_ptr ends at 0.
REQ-036 Backpressure: F3 holds tag 5 while F0 and F1 stream continuously -> F3 is broadcast within 3 cycles; fu_ready[2]=0 until it is granted; no result is duplicated.
REQ-037 Same-cycle refill: F1 hold granted while F1 presents new tag 3, value 0x00FF -> fu_ready[1]=1; tag 3 broadcasts on the next eligible grant.
REQ-038 Flush: two holds full, flush=1 for one cycle -> cdb_valid=0 on the next edge; no stale tag appears afterward; rr_ptr is unchanged.
REQ-039 Async reset: rst_n dropped mid-cycle while cdb_valid=1 -> outputs zero before the next clk edge; after release, fu_ready=111 and rr_ptr=0.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants: datapath widths, FU numbering and small
// helpers used by the common-data-bus writeback logic.
package tomasulo_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int NUM_FU = 3;
  localparam int PTR_W  = 2;

  typedef logic [PTR_W-1:0] fu_idx_t;

  localparam fu_idx_t FU_ADD0   = 2'd0;
  localparam fu_idx_t FU_ADD1   = 2'd1;
  localparam fu_idx_t FU_MULDIV = 2'd2;

  // Encode a one-hot three-way grant into an FU index (zero when idle).
  function automatic fu_idx_t onehot_to_idx(input logic [2:0] oh);
    fu_idx_t idx;
    case (oh)
      3'b010:  idx = FU_ADD1;
      3'b100:  idx = FU_MULDIV;
      default: idx = FU_ADD0;
    endcase
    return idx;
  endfunction

  // Round-robin successor: the FU just served drops to lowest priority.
  function automatic fu_idx_t next_ptr(input fu_idx_t g);
    fu_idx_t n;
    if (g == FU_MULDIV) n = FU_ADD0;
    else                n = g + 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: the search starts at ptr and wraps
// upward; the first requesting index wins. Purely combinational.
module rr_arbiter3 (
  input  logic [2:0] request,
  input  logic [1:0] ptr,
  output logic [2:0] grant,
  output logic       any_grant
);
  import tomasulo_pkg::*;

  // Priority order rotates with ptr: ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    grant = 3'b000;
    case (ptr)
      FU_ADD1: begin
        if      (request[1]) grant = 3'b010;
        else if (request[2]) grant = 3'b100;
        else if (request[0]) grant = 3'b001;
      end
      FU_MULDIV: begin
        if      (request[2]) grant = 3'b100;
        else if (request[0]) grant = 3'b001;
        else if (request[1]) grant = 3'b010;
      end
      default: begin
        if      (request[0]) grant = 3'b001;
        else if (request[1]) grant = 3'b010;
        else if (request[2]) grant = 3'b100;
      end
    endcase
  end

  assign any_grant = |grant;

endmodule

// File: rtl/cdb_writeback.sv
// Common-data-bus writeback: one holding register per functional unit,
// round-robin selection of one held result per cycle, and a registered
// broadcast of the winner together with a release pulse to its FU.
module cdb_writeback #(
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int TAG_W  = tomasulo_pkg::TAG_W,
  parameter int NUM_FU = tomasulo_pkg::NUM_FU
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_value,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_value,
  output logic [1:0]               cdb_src,
  output logic [NUM_FU-1:0]        fu_release
);
  import tomasulo_pkg::*;

  logic [NUM_FU-1:0] hold_valid;
  logic [TAG_W-1:0]  hold_tag   [NUM_FU];
  logic [DATA_W-1:0] hold_value [NUM_FU];
  logic [1:0]        rr_ptr;

  logic [2:0]        grant;
  logic              any_grant;
  fu_idx_t           grant_idx;
  logic [NUM_FU-1:0] accept;

  rr_arbiter3 u_arb (
    .request   (hold_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .any_grant (any_grant)
  );

  assign grant_idx = onehot_to_idx(grant);

  // A hold accepts when empty or when it drains this cycle; flush blocks
  // all accepts so nothing new slips in behind the clear.
  assign fu_ready = flush ? '0 : (~hold_valid | grant);
  assign accept   = fu_valid & fu_ready;

  // Hold occupancy: drain the granted entry, refill any accepted entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     hold_valid <= '0;
    else if (flush) hold_valid <= '0;
    else            hold_valid <= (hold_valid & ~grant) | accept;
  end

  // Hold payload: captured on accept, otherwise left untouched.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i]) begin
        hold_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
        hold_value[i] <= fu_value[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin pointer advances past the winner; idle and flush keep it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rr_ptr <= FU_ADD0;
    else if (!flush && any_grant)  rr_ptr <= next_ptr(grant_idx);
  end

  // Broadcast register: load the winner, or idle with payload retained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
      cdb_src    <= '0;
      fu_release <= '0;
    end else if (flush || !any_grant) begin
      cdb_valid  <= 1'b0;
      fu_release <= '0;
    end else begin
      cdb_valid  <= 1'b1;
      cdb_tag    <= hold_tag[grant_idx];
      cdb_value  <= hold_value[grant_idx];
      cdb_src    <= grant_idx;
      fu_release <= grant;
    end
  end

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed bench for cdb_writeback with a queue-level reference model and
// per-cycle comparison, plus literal checks on the documented scenarios.
module tb_cdb_writeback;
  import tomasulo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [2:0]  fu_valid;
  logic [8:0]  fu_tag;
  logic [47:0] fu_value;
  logic [2:0]  fu_ready;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_value;
  logic [1:0]  cdb_src;
  logic [2:0]  fu_release;

  always #5 clk = ~clk;

  cdb_writeback dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_tag     (fu_tag),
    .fu_value   (fu_value),
    .fu_ready   (fu_ready),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src),
    .fu_release (fu_release)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Per-FU stimulus queues: {tag, value}; the head stays on the bus until taken.
  logic [18:0] sq [3][16];
  int sh [3];
  int st [3];

  task automatic push(input int i, input logic [2:0] tag, input logic [15:0] val);
    sq[i][st[i]] = {tag, val};
    st[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (sh[i] < st[i]) begin
        fu_valid[i]          = 1'b1;
        fu_tag[i*3 +: 3]     = sq[i][sh[i]][18:16];
        fu_value[i*16 +: 16] = sq[i][sh[i]][15:0];
      end else begin
        fu_valid[i]          = 1'b0;
        fu_tag[i*3 +: 3]     = 3'd0;
        fu_value[i*16 +: 16] = 16'd0;
      end
    end
  endtask

  // Reference model: each FU has a single result slot; the bus serves the
  // first occupied slot at or after the turn pointer, one per cycle.
  int          m_v   [3];
  logic [2:0]  m_tag [3];
  logic [15:0] m_val [3];
  int          m_ptr;
  int          acc   [3];
  logic        e_cv;
  logic [2:0]  e_tag;
  logic [15:0] e_val;
  logic [1:0]  e_src;
  logic [2:0]  e_rel;

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 0; acc[i] = 0;
    end
    m_ptr = 0; e_cv = 1'b0; e_tag = 3'd0; e_val = 16'd0; e_src = 2'd0; e_rel = 3'd0;
  endfunction

  function automatic int m_next();
    for (int k = 0; k < 3; k++) begin
      if (m_v[(m_ptr + k) % 3] != 0) return (m_ptr + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] m_ready();
    logic [2:0] r;
    int w;
    w = m_next();
    for (int i = 0; i < 3; i++) r[i] = !flush && (m_v[i] == 0 || w == i);
    return r;
  endfunction

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      int w;
      logic [2:0] rdy;
      rdy = m_ready();
      w   = m_next();
      for (int i = 0; i < 3; i++) acc[i] = (fu_valid[i] && rdy[i]) ? 1 : 0;
      if (flush) begin
        for (int i = 0; i < 3; i++) m_v[i] = 0;
        e_cv = 1'b0; e_rel = 3'd0;
      end else begin
        if (w >= 0) begin
          e_cv = 1'b1; e_tag = m_tag[w]; e_val = m_val[w];
          e_src = w[1:0]; e_rel = 3'(1 << w);
          m_v[w] = 0; m_ptr = (w + 1) % 3;
        end else begin
          e_cv = 1'b0; e_rel = 3'd0;
        end
        for (int i = 0; i < 3; i++) begin
          if (acc[i] != 0) begin
            m_v[i] = 1; m_tag[i] = fu_tag[i*3 +: 3]; m_val[i] = fu_value[i*16 +: 16];
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking && rst_n === 1'b1) begin
      chk("cdb_valid",  32'(cdb_valid),  32'(e_cv));
      chk("cdb_tag",    32'(cdb_tag),    32'(e_tag));
      chk("cdb_value",  32'(cdb_value),  32'(e_val));
      chk("cdb_src",    32'(cdb_src),    32'(e_src));
      chk("fu_release", 32'(fu_release), 32'(e_rel));
      chk("fu_ready",   32'(fu_ready),   32'(m_ready()));
      chk("rr_ptr",     32'(dut.rr_ptr), 32'(m_ptr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (acc[i] != 0) sh[i]++;
    drive();
  endtask

  task automatic expect_bus(string name, logic v, logic [2:0] tag, logic [15:0] val,
                            logic [1:0] src, logic [2:0] rel);
    chk({name, ".valid"},   32'(cdb_valid),  32'(v));
    chk({name, ".tag"},     32'(cdb_tag),    32'(tag));
    chk({name, ".value"},   32'(cdb_value),  32'(val));
    chk({name, ".src"},     32'(cdb_src),    32'(src));
    chk({name, ".release"}, 32'(fu_release), 32'(rel));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin sh[i] = 0; st[i] = 0; end
    model_clear();
    drive();
    tick();
    tick();
    expect_bus("reset", 1'b0, 3'd0, 16'd0, 2'd0, 3'd0);
    rst_n = 1'b1;
    #1;
    chk("reset.fu_ready", 32'(fu_ready), 32'h7);
    chk("reset.rr_ptr",   32'(dut.rr_ptr), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f2_at, f2_cnt, n_bc;
    rst_n = 1'b0; flush = 1'b0;
    fu_valid = 3'd0; fu_tag = 9'd0; fu_value = 48'd0;
    for (int i = 0; i < 3; i++) begin sh[i] = 0; st[i] = 0; end
    model_clear();
    do_reset();
    checking = 1'b1;

    // Single result from F0: tag 2, value 0x0007.
    push(0, 3'd2, 16'h0007);
    drive();
    tick();
    chk("single.accept_edge_valid", 32'(cdb_valid), 32'h0);
    tick();
    expect_bus("single", 1'b1, 3'd2, 16'h0007, 2'd0, 3'b001);
    tick();
    expect_bus("single.idle", 1'b0, 3'd2, 16'h0007, 2'd0, 3'b000);

    // Three-way collision from rr_ptr 0.
    do_reset();
    push(0, 3'd0, 16'h0001);
    push(1, 3'd1, 16'h0002);
    push(2, 3'd4, 16'h0030);
    drive();
    tick();
    chk("coll.all_accepted", 32'(sh[0] + sh[1] + sh[2]), 32'd3);
    tick();
    expect_bus("coll.c1", 1'b1, 3'd0, 16'h0001, 2'd0, 3'b001);
    tick();
    expect_bus("coll.c2", 1'b1, 3'd1, 16'h0002, 2'd1, 3'b010);
    tick();
    expect_bus("coll.c3", 1'b1, 3'd4, 16'h0030, 2'd2, 3'b100);
    chk("coll.model_ptr", 32'(m_ptr), 32'h0);
    chk("coll.rr_ptr", 32'(dut.rr_ptr), 32'h0);
    tick();
    chk("coll.drained", 32'(cdb_valid), 32'h0);

    // Backpressure: F3 waits with tag 5 while F0/F1 stream continuously.
    push(2, 3'd5, 16'h8001);
    push(2, 3'd6, 16'h0606);
    push(0, 3'd0, 16'hFFFF); push(0, 3'd1, 16'h0101);
    push(0, 3'd2, 16'h0202); push(0, 3'd3, 16'h0303);
    push(1, 3'd0, 16'h1111); push(1, 3'd1, 16'h2222);
    push(1, 3'd2, 16'h3333); push(1, 3'd3, 16'h4444);
    drive();
    f2_at = -1; f2_cnt = 0; n_bc = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (cdb_valid) n_bc++;
      if (cdb_valid && cdb_src == 2'd2 && cdb_tag == 3'd5) begin
        f2_cnt++;
        if (f2_at < 0) f2_at = n;
      end
      if (n == 2) chk("bp.f2_stalled_ready", 32'(fu_ready[2]), 32'h0);
    end
    chk("bp.f2_edge", 32'(f2_at), 32'd4);
    chk("bp.f2_once", 32'(f2_cnt), 32'd1);
    chk("bp.total_broadcasts", 32'(n_bc), 32'd10);
    chk("bp.last_value_full_width", 32'(cdb_value), 32'h4444);

    // Same-cycle refill on F1 (rr_ptr now 2).
    push(1, 3'd2, 16'h00AA);
    push(1, 3'd3, 16'h00FF);
    drive();
    tick();
    chk("refill.fu_ready1", 32'(fu_ready[1]), 32'h1);
    tick();
    expect_bus("refill.first", 1'b1, 3'd2, 16'h00AA, 2'd1, 3'b010);
    tick();
    expect_bus("refill.second", 1'b1, 3'd3, 16'h00FF, 2'd1, 3'b010);

    // Flush with two holds full; rr_ptr was left at 2.
    push(0, 3'd1, 16'h0011);
    push(2, 3'd6, 16'h0066);
    drive();
    tick();
    flush = 1'b1;
    #1;
    chk("flush.fu_ready", 32'(fu_ready), 32'h0);
    tick();
    flush = 1'b0;
    chk("flush.valid", 32'(cdb_valid), 32'h0);
    chk("flush.release", 32'(fu_release), 32'h0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("flush.no_stale", 32'(cdb_valid), 32'h0);
    end
    chk("flush.rr_ptr", 32'(dut.rr_ptr), 32'h2);

    // Asynchronous reset mid-broadcast with another hold still full.
    push(0, 3'd3, 16'h1234);
    push(1, 3'd0, 16'h5555);
    drive();
    tick();
    tick();
    expect_bus("areset.pre", 1'b1, 3'd3, 16'h1234, 2'd0, 3'b001);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin sh[i] = 0; st[i] = 0; end
    drive();
    #1;
    expect_bus("areset.async", 1'b0, 3'd0, 16'd0, 2'd0, 3'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("areset.fu_ready", 32'(fu_ready), 32'h7);
    chk("areset.rr_ptr", 32'(dut.rr_ptr), 32'h0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("areset.discarded", 32'(cdb_valid), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
